// File: rtl/axi_lite_master_if.sv
// AXI-Lite channel bundle between an initiator and a register slave.
// Master drives address/data/ready-for-response; slave drives the rest.
interface axi_lite_master_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] aw_addr;
  logic                  aw_valid;
  logic                  aw_ready;

  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic                  w_valid;
  logic                  w_ready;

  logic [1:0]            b_resp;
  logic                  b_valid;
  logic                  b_ready;

  logic [ADDR_WIDTH-1:0] ar_addr;
  logic                  ar_valid;
  logic                  ar_ready;

  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic                  r_valid;
  logic                  r_ready;

  modport master (
    output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );

  modport slave (
    input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-Lite initiator: one command in, one AXI transaction out,
// one response back. All AXI outputs are registered; no AXI input reaches an AXI output.
module axi_lite_master #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4,
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  axi_lite_master_if.master     axi_l,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_write_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic [1:0]            rsp_resp_o,
  output logic                  busy_o
);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StWresp,
    StRead,
    StRdata,
    StResp
  } state_e;

  state_e                state_q;
  logic                  aw_valid_q;
  logic                  w_valid_q;
  logic                  b_ready_q;
  logic                  ar_valid_q;
  logic                  r_ready_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic                  rsp_valid_q;
  logic                  rsp_write_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [1:0]            rsp_resp_q;

  // A channel counts as done once its valid is already low or handshakes this cycle.
  logic aw_done;
  logic w_done;
  assign aw_done = !aw_valid_q || axi_l.aw_ready;
  assign w_done  = !w_valid_q  || axi_l.w_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      b_ready_q   <= 1'b0;
      ar_valid_q  <= 1'b0;
      r_ready_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid_i) begin
            addr_q  <= cmd_addr_i;
            wdata_q <= cmd_wdata_i;
            wstrb_q <= cmd_wstrb_i;
            if (cmd_write_i) begin
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
              state_q    <= StWrite;
            end else begin
              ar_valid_q <= 1'b1;
              state_q    <= StRead;
            end
          end
        end
        StWrite: begin
          if (aw_valid_q && axi_l.aw_ready) aw_valid_q <= 1'b0;
          if (w_valid_q && axi_l.w_ready)   w_valid_q  <= 1'b0;
          if (aw_done && w_done) begin
            b_ready_q <= 1'b1;
            state_q   <= StWresp;
          end
        end
        StWresp: begin
          if (axi_l.b_valid) begin
            rsp_resp_q  <= axi_l.b_resp;
            rsp_write_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b1;
            b_ready_q   <= 1'b0;
            state_q     <= StResp;
          end
        end
        StRead: begin
          if (axi_l.ar_ready) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state_q    <= StRdata;
          end
        end
        StRdata: begin
          if (axi_l.r_valid) begin
            rsp_resp_q  <= axi_l.r_resp;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= axi_l.r_data;
            rsp_valid_q <= 1'b1;
            r_ready_q   <= 1'b0;
            state_q     <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign axi_l.aw_addr  = addr_q;
  assign axi_l.aw_valid = aw_valid_q;
  assign axi_l.w_data   = wdata_q;
  assign axi_l.w_strb   = wstrb_q;
  assign axi_l.w_valid  = w_valid_q;
  assign axi_l.b_ready  = b_ready_q;
  assign axi_l.ar_addr  = addr_q;
  assign axi_l.ar_valid = ar_valid_q;
  assign axi_l.r_ready  = r_ready_q;

  // Held low during reset so no command is taken while state is being cleared.
  assign cmd_ready_o = (state_q == StIdle) && !rst_i;
  assign busy_o      = (state_q != StIdle);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_write_o = rsp_write_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_resp_o  = rsp_resp_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: vector table plus reset and back-to-back sequences.
`timescale 1ns/1ps
module tb_axi_lite_master;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned SW = 4;

  logic          clk = 1'b1;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_wstrb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          busy;

  axi_lite_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) axi ();

  axi_lite_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .axi_l       (axi),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_write_i (cmd_write),
    .cmd_addr_i  (cmd_addr),
    .cmd_wdata_i (cmd_wdata),
    .cmd_wstrb_i (cmd_wstrb),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_write_o (rsp_write),
    .rsp_rdata_o (rsp_rdata),
    .rsp_resp_o  (rsp_resp),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  // Slave model knobs, written by the main sequence.
  int            aw_lat = 0, w_lat = 0, ar_lat = 0;
  logic          b_en = 1'b1;
  logic [1:0]    s_bresp = 2'b00, s_rresp = 2'b00;
  logic [DW-1:0] s_rdata = '0;

  int aw_wait = 0, w_wait = 0, ar_wait = 0;
  always @(negedge clk) begin
    axi.aw_ready = axi.aw_valid && (aw_wait >= aw_lat);
    aw_wait      = axi.aw_valid ? aw_wait + 1 : 0;
    axi.w_ready  = axi.w_valid && (w_wait >= w_lat);
    w_wait       = axi.w_valid ? w_wait + 1 : 0;
    axi.ar_ready = axi.ar_valid && (ar_wait >= ar_lat);
    ar_wait      = axi.ar_valid ? ar_wait + 1 : 0;
    axi.b_valid  = axi.b_ready && b_en;
    axi.b_resp   = s_bresp;
    axi.r_valid  = axi.r_ready;
    axi.r_data   = s_rdata;
    axi.r_resp   = s_rresp;
  end

  // Monitor: handshake counts, cycle stamps, captured payloads, protocol violations.
  int            cyc = 0;
  int            n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, n_acc = 0, n_rsp = 0, n_viol = 0;
  int            aw_hs_cyc = 0, w_hs_cyc = 0, ar_hs_cyc = 0;
  logic [AW-1:0] aw_hs_addr, ar_hs_addr;
  logic [DW-1:0] w_hs_data;
  logic [SW-1:0] w_hs_strb;
  int            acc_cyc[16];
  int            rsp_cyc[16];
  logic [DW-1:0] rsp_cap_rdata[16];
  logic          rsp_cap_write[16];
  logic          p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0, p_arv = 1'b0, p_arr = 1'b0;
  logic [AW-1:0] p_awa, p_ara;
  logic [DW-1:0] p_wd;
  logic [SW-1:0] p_ws;

  always @(posedge clk) begin
    if (!rst) begin
      if (axi.aw_valid && axi.aw_ready) begin
        n_aw++; aw_hs_cyc = cyc; aw_hs_addr = axi.aw_addr;
      end
      if (axi.w_valid && axi.w_ready) begin
        n_w++; w_hs_cyc = cyc; w_hs_data = axi.w_data; w_hs_strb = axi.w_strb;
      end
      if (axi.ar_valid && axi.ar_ready) begin
        n_ar++; ar_hs_cyc = cyc; ar_hs_addr = axi.ar_addr;
      end
      if (axi.b_valid && axi.b_ready) n_b++;
      if (axi.r_valid && axi.r_ready) n_r++;
      if (cmd_valid && cmd_ready) begin
        acc_cyc[n_acc % 16] = cyc; n_acc++;
      end
      if (rsp_valid && rsp_ready) begin
        rsp_cyc[n_rsp % 16] = cyc;
        rsp_cap_rdata[n_rsp % 16] = rsp_rdata;
        rsp_cap_write[n_rsp % 16] = rsp_write;
        n_rsp++;
      end
      if (cmd_ready && rsp_valid) n_viol++;
      if (p_awv && !p_awr && (!axi.aw_valid || axi.aw_addr != p_awa)) n_viol++;
      if (p_wv && !p_wr && (!axi.w_valid || axi.w_data != p_wd || axi.w_strb != p_ws)) n_viol++;
      if (p_arv && !p_arr && (!axi.ar_valid || axi.ar_addr != p_ara)) n_viol++;
    end
    p_awv = axi.aw_valid; p_awr = axi.aw_ready; p_awa = axi.aw_addr;
    p_wv  = axi.w_valid;  p_wr  = axi.w_ready;  p_wd  = axi.w_data; p_ws = axi.w_strb;
    p_arv = axi.ar_valid; p_arr = axi.ar_ready; p_ara = axi.ar_addr;
    cyc++;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    int            aw_lat;
    int            w_lat;
    int            ar_lat;
    logic [1:0]    sresp;
    logic [DW-1:0] srdata;
    int            hold;
    int            exp_lat;
    int            exp_aw_off;
    int            exp_w_off;
    int            exp_ar_off;
    logic [DW-1:0] exp_rdata;
    logic [1:0]    exp_resp;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input int k, input vec_t v);
    int a_cyc, r_cyc, waited;
    int aw0 = n_aw, w0 = n_w, b0 = n_b, ar0 = n_ar, r0 = n_r, viol0 = n_viol;
    @(negedge clk);
    aw_lat = v.aw_lat; w_lat = v.w_lat; ar_lat = v.ar_lat;
    s_bresp = v.sresp; s_rresp = v.sresp; s_rdata = v.srdata; b_en = 1'b1;
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    waited = 0;
    while (!cmd_ready && waited < 20) begin @(negedge clk); waited++; end
    check($sformatf("v%0d accept_ready", k), cmd_ready, 1);
    a_cyc = cyc;
    @(negedge clk);
    // Scramble the command bus so any late sampling shows up in the payload checks.
    cmd_valid = 1'b0; cmd_addr = ~v.addr; cmd_wdata = ~v.wdata; cmd_wstrb = ~v.wstrb;
    waited = 0;
    while (!rsp_valid && waited < 50) begin @(negedge clk); waited++; end
    r_cyc = cyc;
    check($sformatf("v%0d latency", k), r_cyc - a_cyc, v.exp_lat);
    check($sformatf("v%0d rsp_write", k), rsp_write, v.write);
    check($sformatf("v%0d rsp_rdata", k), rsp_rdata, v.exp_rdata);
    check($sformatf("v%0d rsp_resp", k), rsp_resp, v.exp_resp);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      check($sformatf("v%0d hold%0d valid", k, h), rsp_valid, 1);
      check($sformatf("v%0d hold%0d rdata", k, h), rsp_rdata, v.exp_rdata);
      check($sformatf("v%0d hold%0d resp", k, h), rsp_resp, v.exp_resp);
      check($sformatf("v%0d hold%0d cmd_ready", k, h), cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check($sformatf("v%0d post rsp_valid", k), rsp_valid, 0);
    check($sformatf("v%0d post busy", k), busy, 0);
    check($sformatf("v%0d post cmd_ready", k), cmd_ready, 1);
    if (v.write) begin
      check($sformatf("v%0d n_aw", k), n_aw - aw0, 1);
      check($sformatf("v%0d n_w", k), n_w - w0, 1);
      check($sformatf("v%0d n_b", k), n_b - b0, 1);
      check($sformatf("v%0d n_ar", k), n_ar - ar0, 0);
      check($sformatf("v%0d aw_off", k), aw_hs_cyc - a_cyc, v.exp_aw_off);
      check($sformatf("v%0d w_off", k), w_hs_cyc - a_cyc, v.exp_w_off);
      check($sformatf("v%0d aw_addr", k), aw_hs_addr, v.addr);
      check($sformatf("v%0d w_data", k), w_hs_data, v.wdata);
      check($sformatf("v%0d w_strb", k), w_hs_strb, v.wstrb);
    end else begin
      check($sformatf("v%0d n_ar", k), n_ar - ar0, 1);
      check($sformatf("v%0d n_r", k), n_r - r0, 1);
      check($sformatf("v%0d n_aw", k), n_aw - aw0, 0);
      check($sformatf("v%0d ar_off", k), ar_hs_cyc - a_cyc, v.exp_ar_off);
      check($sformatf("v%0d ar_addr", k), ar_hs_addr, v.addr);
    end
    check($sformatf("v%0d protocol", k), n_viol - viol0, 0);
  endtask

  initial begin
    int waited, acc0, rsp0;
    //            wr    addr   wdata         strb  aw w  ar resp   srdata        hold lat aw w ar exp_rdata     exp_resp
    vecs[0] = '{1'b1, 4'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 32'h0,        0,   3,  1, 1, 0, 32'h0,        2'b00};
    vecs[1] = '{1'b0, 4'h8, 32'h0,        4'h0, 0, 0, 3, 2'b00, 32'h12345678, 0,   6,  0, 0, 4, 32'h12345678, 2'b00};
    vecs[2] = '{1'b1, 4'hC, 32'hA5A55A5A, 4'h3, 3, 1, 0, 2'b00, 32'hFFFFFFFF, 0,   6,  4, 2, 0, 32'h0,        2'b00};
    vecs[3] = '{1'b0, 4'h0, 32'h0,        4'h0, 0, 0, 0, 2'b10, 32'hCAFEF00D, 5,   3,  0, 0, 1, 32'hCAFEF00D, 2'b10};
    vecs[4] = '{1'b1, 4'h8, 32'h01020304, 4'h8, 0, 2, 0, 2'b11, 32'h0,        0,   5,  1, 3, 0, 32'h0,        2'b11};
    vecs[5] = '{1'b0, 4'hC, 32'h0,        4'h0, 0, 0, 0, 2'b01, 32'h0F0F0F0F, 1,   3,  0, 0, 1, 32'h0F0F0F0F, 2'b01};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst cmd_ready", cmd_ready, 0);
    check("rst busy", busy, 0);
    check("rst rsp_valid", rsp_valid, 0);
    check("rst valids", {axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready}, 0);
    check("rst rsp_data", {rsp_write, rsp_resp, rsp_rdata}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post rst cmd_ready", cmd_ready, 1);

    for (int k = 0; k < 6; k++) run_vec(k, vecs[k]);

    // Reset while aw is stalled in WRITE: valids fall without a clock edge.
    @(negedge clk);
    aw_lat = 100; w_lat = 100; b_en = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h4; cmd_wdata = 32'h11; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("stall aw_valid", {axi.aw_valid, axi.w_valid}, 2'b11);
    #1 rst = 1'b1;
    #1;
    check("async rst write valids", {axi.aw_valid, axi.w_valid, busy}, 0);
    @(negedge clk);
    rst = 1'b0; aw_lat = 0; w_lat = 0;

    // Reset while in WRESP with the slave withholding b_valid.
    @(negedge clk);
    b_en = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h8; cmd_wdata = 32'h22; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    waited = 0;
    while (!axi.b_ready && waited < 20) begin @(negedge clk); waited++; end
    check("wresp b_ready", {axi.b_ready, busy}, 2'b11);
    #1 rst = 1'b1;
    #1;
    check("async rst wresp", {axi.aw_valid, axi.w_valid, axi.b_ready, busy, cmd_ready}, 0);
    @(negedge clk);
    rst = 1'b0; b_en = 1'b1;
    @(negedge clk);
    check("after rst idle", {cmd_ready, busy, rsp_valid}, 3'b100);

    // Back-to-back read then write with cmd_valid held high.
    @(negedge clk);
    acc0 = n_acc; rsp0 = n_rsp;
    aw_lat = 0; w_lat = 0; ar_lat = 0; s_rdata = 32'h55AA00FF; s_rresp = 2'b00; s_bresp = 2'b00;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h4;
    waited = 0;
    while (n_acc - acc0 < 1 && waited < 20) begin @(negedge clk); waited++; end
    cmd_write = 1'b1; cmd_addr = 4'h8; cmd_wdata = 32'h77; cmd_wstrb = 4'h1;
    waited = 0;
    while (n_acc - acc0 < 2 && waited < 20) begin @(negedge clk); waited++; end
    cmd_valid = 1'b0;
    waited = 0;
    while (n_rsp - rsp0 < 2 && waited < 20) begin @(negedge clk); waited++; end
    rsp_ready = 1'b0;
    check("b2b accepts", n_acc - acc0, 2);
    check("b2b responses", n_rsp - rsp0, 2);
    check("b2b read latency", rsp_cyc[rsp0 % 16] - acc_cyc[acc0 % 16], 3);
    check("b2b gap", acc_cyc[(acc0 + 1) % 16] - rsp_cyc[rsp0 % 16], 1);
    check("b2b rd data", rsp_cap_rdata[rsp0 % 16], 32'h55AA00FF);
    check("b2b rd write", rsp_cap_write[rsp0 % 16], 0);
    check("b2b wr write", rsp_cap_write[(rsp0 + 1) % 16], 1);
    check("b2b wr rdata", rsp_cap_rdata[(rsp0 + 1) % 16], 0);
    check("b2b w_data", {w_hs_strb, w_hs_data}, {4'h1, 32'h77});

    check("protocol total", n_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
